// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-channel to SDRAM toggle-port bridge.
package mem_bridge_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;

  localparam int MAX_CH = 8;

  // Writes drive the single lane holding the addressed byte; reads fetch the whole word.
  function automatic logic [1:0] ds_for(input logic we, input logic a0);
    if (!we) return DS_BOTH;
    return a0 ? DS_HI : DS_LO;
  endfunction

endpackage

// File: rtl/mem_port_event.sv
// Per-channel access event detector with excluded-window filter and a single
// coalescing request slot (latest event wins).
module mem_port_event #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] EXCL_MASK = 16'hC000,
  parameter logic [ADDR_W-1:0] EXCL_VAL  = 16'hC000
) (
  input  logic              i_clk,
  input  logic              i_res_n,
  input  logic              i_cs,
  input  logic              i_oe,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_d,
  input  logic              i_clr,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we,
  output logic [7:0]        o_d
);

  logic              r_rd, r_wr, r_pend, r_we;
  logic [ADDR_W-1:0] r_addr_hist, r_addr;
  logic [7:0]        r_d;

  logic w_excl, w_rd, w_wr, w_rd_ev, w_wr_ev, w_event;

  assign w_excl  = (EXCL_MASK != '0) && ((i_addr & EXCL_MASK) == EXCL_VAL);
  assign w_rd    = i_cs & ~w_excl & i_oe;
  assign w_wr    = i_cs & ~w_excl & i_we;
  assign w_rd_ev = w_rd & (~r_rd | (i_addr != r_addr_hist));
  assign w_wr_ev = w_wr & ~r_wr;
  assign w_event = w_rd_ev | w_wr_ev;

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr_hist <= '0;
      r_pend      <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_d         <= '0;
    end else begin
      r_rd        <= w_rd;
      r_wr        <= w_wr;
      r_addr_hist <= i_addr;
      // A new event in the same cycle the arbiter copies the slot keeps it pending.
      if (w_event) begin
        r_pend <= 1'b1;
        r_addr <= i_addr;
        r_we   <= w_wr_ev;
        r_d    <= i_d;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_addr = r_addr;
  assign o_we   = r_we;
  assign o_d    = r_d;

endmodule

// File: rtl/mem_port_bridge.sv
// Round-robin bridge from NUM_CH byte-wide CPU-style channels onto one
// toggle-handshake 16-bit SDRAM port.
module mem_port_bridge
  import mem_bridge_pkg::*;
#(
  parameter int                NUM_CH    = 2,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] EXCL_MASK = 16'hC000,
  parameter logic [ADDR_W-1:0] EXCL_VAL  = 16'hC000
) (
  input  logic                     i_clk,
  input  logic                     i_res_n,
  input  logic [NUM_CH-1:0]        i_ch_cs,
  input  logic [NUM_CH-1:0]        i_ch_oe,
  input  logic [NUM_CH-1:0]        i_ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_addr,
  input  logic [NUM_CH*8-1:0]      i_ch_d,
  output logic [NUM_CH*8-1:0]      o_ch_q,
  output logic [NUM_CH-1:0]        o_ch_busy,
  output logic                     o_mem_req,
  input  logic                     i_mem_ack,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic                     o_mem_we,
  output logic [1:0]               o_mem_ds,
  output logic [15:0]              o_mem_d,
  input  logic [15:0]              i_mem_q
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]             w_pend, w_slot_we, w_clr, w_busy;
  logic [NUM_CH-1:0][ADDR_W-1:0] w_slot_addr;
  logic [NUM_CH-1:0][7:0]        w_slot_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mem_port_event #(
      .ADDR_W   (ADDR_W),
      .EXCL_MASK(EXCL_MASK),
      .EXCL_VAL (EXCL_VAL)
    ) u_event (
      .i_clk  (i_clk),
      .i_res_n(i_res_n),
      .i_cs   (i_ch_cs[i]),
      .i_oe   (i_ch_oe[i]),
      .i_we   (i_ch_we[i]),
      .i_addr (i_ch_addr[i*ADDR_W +: ADDR_W]),
      .i_d    (i_ch_d[i*8 +: 8]),
      .i_clr  (w_clr[i]),
      .o_pend (w_pend[i]),
      .o_addr (w_slot_addr[i]),
      .o_we   (w_slot_we[i]),
      .o_d    (w_slot_d[i])
    );
  end

  state_t                 r_state;
  logic [GW-1:0]          r_grant, r_rr;
  logic                   r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [1:0]             r_mem_ds;
  logic [15:0]            r_mem_d;
  logic [NUM_CH-1:0][7:0] r_ch_q;

  logic          w_found_hi, w_found_lo, w_found;
  logic [GW-1:0] w_sel_hi, w_sel_lo, w_sel;

  // First pending at or above the pointer, otherwise the lowest pending (wrap).
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_pend[i] && !w_found_hi && (GW'(i) >= r_rr)) begin
        w_found_hi = 1'b1;
        w_sel_hi   = GW'(i);
      end
      if (w_pend[i] && !w_found_lo) begin
        w_found_lo = 1'b1;
        w_sel_lo   = GW'(i);
      end
    end
    w_found = w_found_hi | w_found_lo;
    w_sel   = w_found_hi ? w_sel_hi : w_sel_lo;
  end

  always_comb begin
    w_clr  = '0;
    w_busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_clr[i]  = (r_state == IDLE) && w_found && (w_sel == GW'(i));
      w_busy[i] = w_pend[i] | ((r_state == WAIT) && (r_grant == GW'(i)));
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr       <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_ds   <= 2'b00;
      r_mem_d    <= '0;
      r_ch_q     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant    <= w_sel;
            r_mem_addr <= w_slot_addr[w_sel];
            r_mem_we   <= w_slot_we[w_sel];
            r_mem_ds   <= ds_for(w_slot_we[w_sel], w_slot_addr[w_sel][0]);
            r_mem_d    <= {w_slot_d[w_sel], w_slot_d[w_sel]};
            r_mem_req  <= ~r_mem_req;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_ack == r_mem_req) begin
            if (!r_mem_we)
              r_ch_q[r_grant] <= r_mem_addr[0] ? i_mem_q[15:8] : i_mem_q[7:0];
            r_rr    <= (r_grant == GW'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ch_q     = r_ch_q;
  assign o_ch_busy  = w_busy;
  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_we   = r_mem_we;
  assign o_mem_ds   = r_mem_ds;
  assign o_mem_d    = r_mem_d;

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed bench for mem_port_bridge: toggle-handshake SDRAM model that checks
// each issued request against a scoreboard of expected transactions.
module tb_mem_port_bridge;

  logic        clk = 1'b0;
  logic        res_n;
  logic [1:0]  ch_cs, ch_oe, ch_we;
  logic [31:0] ch_addr;
  logic [15:0] ch_d;
  logic [15:0] ch_q;
  logic [1:0]  ch_busy;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;
  logic [15:0] mem_q = 16'h0000;

  mem_port_bridge dut (
    .i_clk     (clk),
    .i_res_n   (res_n),
    .i_ch_cs   (ch_cs),
    .i_ch_oe   (ch_oe),
    .i_ch_we   (ch_we),
    .i_ch_addr (ch_addr),
    .i_ch_d    (ch_d),
    .o_ch_q    (ch_q),
    .o_ch_busy (ch_busy),
    .o_mem_req (mem_req),
    .i_mem_ack (mem_ack),
    .o_mem_addr(mem_addr),
    .o_mem_we  (mem_we),
    .o_mem_ds  (mem_ds),
    .o_mem_d   (mem_d),
    .i_mem_q   (mem_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [15:0] rdata;
  } txn_t;

  txn_t sb[$];
  txn_t cur;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_issue = 0;
  int   ack_dly = 5;
  int   cnt     = -1;
  logic prev_req = 1'b0;
  logic [15:0] cur_rdata = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input logic [15:0] addr, input logic we, input logic [7:0] d,
                      input logic [15:0] rdata);
    txn_t t;
    t.addr  = addr;
    t.we    = we;
    t.ds    = we ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
    t.d     = {d, d};
    t.rdata = rdata;
    sb.push_back(t);
  endtask

  task automatic drive(input int ch, input logic cs, input logic oe, input logic we,
                       input logic [15:0] addr, input logic [7:0] d);
    ch_cs[ch]            = cs;
    ch_oe[ch]            = oe;
    ch_we[ch]            = we;
    ch_addr[ch*16 +: 16] = addr;
    ch_d[ch*8 +: 8]      = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    step();
    ch_cs = '0; ch_oe = '0; ch_we = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while (ch_busy != 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n >= budget), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // SDRAM controller model: acknowledges each request toggle after ack_dly cycles.
  always @(negedge clk) begin
    if (!res_n) begin
      mem_ack  = 1'b0;
      prev_req = 1'b0;
      cnt      = -1;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_q   = cur_rdata;
          mem_ack = mem_req;
          cnt     = -1;
        end
      end
      if (mem_req != prev_req) begin
        prev_req = mem_req;
        n_issue++;
        if (sb.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
          cur_rdata = 16'h0000;
        end else begin
          cur = sb.pop_front();
          check("req_addr", 32'(mem_addr), 32'(cur.addr));
          check("req_we", 32'(mem_we), 32'(cur.we));
          check("req_ds", 32'(mem_ds), 32'(cur.ds));
          if (cur.we) check("req_d", 32'(mem_d), 32'(cur.d));
          cur_rdata = cur.rdata;
        end
        cnt = ack_dly;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int issues0;
    ch_cs = '0; ch_oe = '0; ch_we = '0; ch_addr = '0; ch_d = '0;
    res_n = 1'b1;
    #2 res_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(ch_busy), 32'd0);
    check("rst_ch_q", 32'(ch_q), 32'd0);
    check("rst_ds", 32'(mem_ds), 32'd0);
    check("rst_addr_we", 32'({mem_addr, mem_we}), 32'd0);
    step();
    res_n = 1'b1;

    // Single read with latency check.
    ack_dly = 5;
    push(16'h1235, 1'b0, 8'h00, 16'hAB12);
    step();
    drive(0, 1, 1, 0, 16'h1235, 8'h00);
    @(negedge clk);
    check("lat_busy_pre", 32'(ch_busy), 32'd0);
    @(negedge clk);
    check("lat_busy_n1", 32'(ch_busy), 32'b01);
    check("lat_req_n1", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("lat_req_n2", 32'(mem_req), 32'd1);
    wait_idle(40);
    check("rd_ch_q0", 32'(ch_q[7:0]), 32'hAB);
    check("rd_count", 32'(n_issue), 32'd1);
    idle_all();

    // Write lanes on channel 1.
    push(16'h0200, 1'b1, 8'h5A, 16'h0000);
    step();
    drive(1, 1, 0, 1, 16'h0200, 8'h5A);
    wait_idle(40);
    step();
    drive(1, 1, 0, 0, 16'h0200, 8'h5A);
    push(16'h0201, 1'b1, 8'h5A, 16'h0000);
    step();
    drive(1, 1, 0, 1, 16'h0201, 8'h5A);
    wait_idle(40);
    check("wr_ch_q1", 32'(ch_q[15:8]), 32'h00);
    check("wr_ch_q0", 32'(ch_q[7:0]), 32'hAB);
    idle_all();

    // Excluded window.
    issues0 = n_issue;
    step();
    drive(0, 1, 1, 0, 16'hC010, 8'h00);
    repeat (3) @(negedge clk);
    check("excl_busy", 32'(ch_busy), 32'd0);
    repeat (8) @(negedge clk);
    check("excl_no_req", 32'(n_issue), 32'(issues0));
    check("excl_ch_q0", 32'(ch_q[7:0]), 32'hAB);
    idle_all();

    // Round robin from pointer 0: ch0 then ch1.
    push(16'h0100, 1'b0, 8'h00, 16'hA1B2);
    push(16'h0301, 1'b0, 8'h00, 16'hC3D4);
    step();
    drive(0, 1, 1, 0, 16'h0100, 8'h00);
    drive(1, 1, 1, 0, 16'h0301, 8'h00);
    wait_idle(60);
    check("rr0_ch_q0", 32'(ch_q[7:0]), 32'hB2);
    check("rr0_ch_q1", 32'(ch_q[15:8]), 32'hC3);
    idle_all();
    push(16'h0102, 1'b0, 8'h00, 16'h0E0F);
    step();
    drive(0, 1, 1, 0, 16'h0102, 8'h00);
    wait_idle(40);
    check("rr_single_q0", 32'(ch_q[7:0]), 32'h0F);
    idle_all();

    // Pointer now 1: ch1 then ch0.
    push(16'h0305, 1'b0, 8'h00, 16'h3344);
    push(16'h0104, 1'b0, 8'h00, 16'h1122);
    step();
    drive(0, 1, 1, 0, 16'h0104, 8'h00);
    drive(1, 1, 1, 0, 16'h0305, 8'h00);
    wait_idle(60);
    check("rr1_ch_q1", 32'(ch_q[15:8]), 32'h33);
    check("rr1_ch_q0", 32'(ch_q[7:0]), 32'h22);
    idle_all();

    // Coalesce: two ch0 events while ch1 is in flight -> one ch0 transaction.
    ack_dly = 12;
    issues0 = n_issue;
    push(16'h0600, 1'b0, 8'h00, 16'h5566);
    push(16'h0011, 1'b0, 8'h00, 16'h7788);
    step();
    drive(1, 1, 1, 0, 16'h0600, 8'h00);
    repeat (3) step();
    drive(0, 1, 1, 0, 16'h0010, 8'h00);
    step();
    drive(0, 1, 1, 0, 16'h0011, 8'h00);
    wait_idle(80);
    check("coal_count", 32'(n_issue - issues0), 32'd2);
    check("coal_ch_q0", 32'(ch_q[7:0]), 32'h77);
    check("coal_ch_q1", 32'(ch_q[15:8]), 32'h66);
    idle_all();

    // Reset while a request is outstanding.
    ack_dly = 20;
    issues0 = n_issue;
    push(16'h0400, 1'b0, 8'h00, 16'hDEAD);
    step();
    drive(0, 1, 1, 0, 16'h0400, 8'h00);
    repeat (4) step();
    check("rstw_issued", 32'(n_issue - issues0), 32'd1);
    check("rstw_busy_pre", 32'(ch_busy), 32'b01);
    res_n = 1'b0;
    #1;
    check("rstw_req", 32'(mem_req), 32'd0);
    check("rstw_busy", 32'(ch_busy), 32'd0);
    check("rstw_ch_q", 32'(ch_q), 32'd0);
    ch_cs = '0; ch_oe = '0; ch_we = '0;
    repeat (2) step();
    res_n = 1'b1;
    ack_dly = 5;
    push(16'h0501, 1'b0, 8'h00, 16'h77C3);
    step();
    drive(1, 1, 1, 0, 16'h0501, 8'h00);
    wait_idle(40);
    check("post_rst_q1", 32'(ch_q[15:8]), 32'h77);
    check("post_rst_q0", 32'(ch_q[7:0]), 32'h00);
    idle_all();

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
